// File: rtl/ef_apb_master_if.sv
// rtl/ef_apb_master_if.sv - command/response and APB requester signal bundle for ef_apb_master
interface ef_apb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/ef_apb_master.sv
// rtl/ef_apb_master.sv - single-outstanding APB requester; EF_APB_MASTER_TIMEOUT_EN adds ACCESS timeout abort
module ef_apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  ef_apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_n;
  logic        cmd_ready_q, cmd_ready_n;
  logic        psel_q, psel_n;
  logic        penable_q, penable_n;
  logic        pwrite_q, pwrite_n;
  logic [31:0] paddr_q, paddr_n;
  logic [31:0] pwdata_q, pwdata_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [31:0] rsp_rdata_q, rsp_rdata_n;
  logic        rsp_err_q, rsp_err_n;

`ifdef EF_APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_n;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= 8'd0;
    else          cnt_q <= cnt_n;
  end
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'd0;
      pwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cmd_ready_q <= cmd_ready_n;
      psel_q      <= psel_n;
      penable_q   <= penable_n;
      pwrite_q    <= pwrite_n;
      paddr_q     <= paddr_n;
      pwdata_q    <= pwdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_err_q   <= rsp_err_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    psel_n      = psel_q;
    penable_n   = penable_q;
    pwrite_n    = pwrite_q;
    paddr_n     = paddr_q;
    pwdata_n    = pwdata_q;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_err_n   = rsp_err_q;
`ifdef EF_APB_MASTER_TIMEOUT_EN
    cnt_n       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready_q is low for the first cycle after reset release
        if (bus.cmd_valid && cmd_ready_q) begin
          state_n   = SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          pwrite_n  = bus.cmd_write;
          paddr_n   = bus.cmd_addr;
          pwdata_n  = bus.cmd_write ? bus.cmd_wdata : 32'd0;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
`ifdef EF_APB_MASTER_TIMEOUT_EN
        cnt_n     = 8'd0;
`endif
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge
        if (bus.PREADY) begin
          state_n     = IDLE;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = pwrite_q ? 32'd0 : bus.PRDATA;
          rsp_err_n   = 1'b0;
        end
`ifdef EF_APB_MASTER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_n     = IDLE;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = 32'd0;
          rsp_err_n   = 1'b1;
          cnt_n       = 8'd0;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ef_apb_master.sv
// tb/tb_ef_apb_master.sv - directed self-checking bench for ef_apb_master
module tb_ef_apb_master;

  logic PCLK;
  logic PRESETn;
  int   n_cmp = 0;
  int   n_bad = 0;

  ef_apb_master_if bus ();

  ef_apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
  endtask

  initial begin
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.PRDATA    = 32'd0;
    bus.PREADY    = 1'b0;
    repeat (2) tick();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_psel",      {31'd0, bus.PSEL},      32'd0);
    check("rst_penable",   {31'd0, bus.PENABLE},   32'd0);
    check("rst_paddr",     bus.PADDR,              32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    PRESETn = 1'b1;
    tick();
    check("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // zero-wait write
    issue(1'b1, 32'h0000_0004, 32'hA5A5_5A5A);
    bus.PREADY = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("wr_setup_psel",    {31'd0, bus.PSEL},      32'd1);
    check("wr_setup_penable", {31'd0, bus.PENABLE},   32'd0);
    check("wr_setup_paddr",   bus.PADDR,              32'h0000_0004);
    check("wr_setup_pwdata",  bus.PWDATA,             32'hA5A5_5A5A);
    check("wr_setup_ready",   {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    check("wr_acc_penable", {31'd0, bus.PENABLE},   32'd1);
    check("wr_acc_pwrite",  {31'd0, bus.PWRITE},    32'd1);
    check("wr_acc_rsp",     {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("wr_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    check("wr_rsp_rdata", bus.rsp_rdata,          32'd0);
    check("wr_done_psel", {31'd0, bus.PSEL},      32'd0);
    check("wr_keep_paddr", bus.PADDR,             32'h0000_0004);
    tick();
    check("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // read with three wait states
    issue(1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hDEAD_BEEF;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 32'h0000_0F00;
    check("rd_pwdata_zero", bus.PWDATA,           32'd0);
    check("rd_pwrite",      {31'd0, bus.PWRITE},  32'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("rd_acc%0d_penable", i), {31'd0, bus.PENABLE},   32'd1);
      check($sformatf("rd_acc%0d_paddr", i),   bus.PADDR,              32'd0);
      check($sformatf("rd_acc%0d_rsp", i),     {31'd0, bus.rsp_valid}, 32'd0);
      if (i == 4) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h1234_5678;
      end
      tick();
    end
    check("rd_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("rd_rsp_rdata", bus.rsp_rdata,          32'h1234_5678);
    bus.PRDATA = 32'h0BAD_0BAD;
    tick();
    check("rd_rdata_hold", bus.rsp_rdata, 32'h1234_5678);

    // back-to-back commands with cmd_valid held high
    issue(1'b1, 32'h0000_0010, 32'h1111_1111);
    tick();
    issue(1'b0, 32'h0000_0020, 32'h2222_2222);
    check("b2b_1_paddr", bus.PADDR, 32'h0000_0010);
    tick();
    check("b2b_1_acc_paddr", bus.PADDR, 32'h0000_0010);
    bus.PRDATA = 32'hCAFE_F00D;
    tick();
    check("b2b_1_rsp",   {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b_1_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_2_psel",   {31'd0, bus.PSEL},      32'd1);
    check("b2b_2_paddr",  bus.PADDR,              32'h0000_0020);
    check("b2b_2_pwrite", {31'd0, bus.PWRITE},    32'd0);
    check("b2b_2_norsp",  {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    tick();
    check("b2b_2_rsp",   {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b_2_rdata", bus.rsp_rdata,          32'hCAFE_F00D);

    // reset asserted mid-ACCESS
    tick();
    issue(1'b1, 32'h0000_0040, 32'h4444_4444);
    bus.PREADY = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("rst_mid_penable_pre", {31'd0, bus.PENABLE}, 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("rst_mid_psel",    {31'd0, bus.PSEL},      32'd0);
    check("rst_mid_penable", {31'd0, bus.PENABLE},   32'd0);
    check("rst_mid_ready",   {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_mid_rdata",   bus.rsp_rdata,          32'd0);
    bus.PREADY = 1'b1;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_mid_norsp%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
    end
    check("rst_mid_ready_after", {31'd0, bus.cmd_ready}, 32'd1);

`ifdef EF_APB_MASTER_TIMEOUT_EN
    // PREADY on the 16th ACCESS cycle completes normally
    issue(1'b0, 32'h0000_0080, 32'd0);
    bus.PREADY = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) tick();
    check("to_edge_penable", {31'd0, bus.PENABLE}, 32'd1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h600D_D00D;
    tick();
    check("to_edge_rsp",   {31'd0, bus.rsp_valid}, 32'd1);
    check("to_edge_err",   {31'd0, bus.rsp_err},   32'd0);
    check("to_edge_rdata", bus.rsp_rdata,          32'h600D_D00D);

    // PREADY held low: abort after 16 ACCESS cycles
    begin
      int acc_cycles;
      acc_cycles = 0;
      issue(1'b0, 32'h0000_00C0, 32'd0);
      bus.PREADY = 1'b0;
      tick();
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 100 && !bus.rsp_valid; k++) begin
        if (bus.PENABLE) acc_cycles++;
        tick();
      end
      check("to_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
      check("to_acc_cycles", acc_cycles,             32'd16);
      check("to_err",        {31'd0, bus.rsp_err},   32'd1);
      check("to_rdata",      bus.rsp_rdata,          32'd0);
      check("to_psel",       {31'd0, bus.PSEL},      32'd0);
    end
`else
    // without the timeout ACCESS waits indefinitely
    begin
      int early_rsp;
      early_rsp = 0;
      issue(1'b0, 32'h0000_00C0, 32'd0);
      bus.PREADY = 1'b0;
      tick();
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < 101; k++) begin
        if (bus.rsp_valid) early_rsp++;
        tick();
      end
      check("nto_penable",   {31'd0, bus.PENABLE}, 32'd1);
      check("nto_psel",      {31'd0, bus.PSEL},    32'd1);
      check("nto_early_rsp", early_rsp,            32'd0);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h600D_D00D;
      tick();
      check("nto_rsp",   {31'd0, bus.rsp_valid}, 32'd1);
      check("nto_err",   {31'd0, bus.rsp_err},   32'd0);
      check("nto_rdata", bus.rsp_rdata,          32'h600D_D00D);
    end
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
